// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS core: load-use, taken beq/j, memory wait.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic             mem_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERROR    = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              lu, mw, resolve;

   // Register 0 is hard-wired, so a load targeting it never creates a dependency.
   assign lu = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign mw = mem_req && !mem_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      resolve     = 1'b0;
      state_d     = state_q;
      wait_d      = wait_q;
      if (rst) begin
         idex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (mw) begin
                  pipe_hold = 1'b1;
                  wait_d    = WAIT_W'(1);
                  state_d   = MEM_WAIT;
               end else begin
                  resolve = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  pipe_hold = 1'b1;
                  if (wait_q == WAIT_MAX) state_d = ERROR;
                  else                    wait_d  = wait_q + 1'b1;
               end else begin
                  // Completion releases the hold and lets the front end resolve this same cycle.
                  resolve = 1'b1;
                  state_d = RUN;
                  wait_d  = '0;
               end
            end
            ERROR: begin
               pipe_hold = 1'b1;
            end
            default: begin
               state_d = RUN;
               wait_d  = '0;
            end
         endcase

         if (resolve) begin
            if (ex_branch_taken) begin
               pc_write   = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (id_jump) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
            end else if (lu) begin
               idex_bubble = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign state   = rst ? RUN : state_q;
   assign mem_err = !rst && (state_q == ERROR);

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_ev;

   // Outside reset a bubble only comes from a load-use stall; ERROR holds are not stalls.
   assign stall_ev = idex_bubble || (pipe_hold && (state_q != ERROR));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_ev && (stall_q != '1))   stall_q <= stall_q + 1'b1;
         if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt = rst ? '0 : stall_q;
   assign flush_cnt = rst ? '0 : flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the main control unit and drives the write-enables and flush/bubble controls of PC, IF/ID, ID/EX and the back-end pipeline registers. It resolves three kinds of event:
- load-use data hazards;
- control hazards from taken `beq` and `j`;
- multi-cycle data-memory accesses, supervised by a timeout watchdog.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum consecutive wait cycles allowed for one memory access.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt as a source (R-type, `beq`, `sw`).
- `id_jump` in 1: the ID instruction is `j`.
- `ex_mem_read` in 1: the ID/EX instruction is `lw`.
- `ex_rt` in 5: destination register of the ID/EX `lw`.
- `ex_branch_taken` in 1: `beq` resolved taken in EX.
- `mem_req` in 1: the MEM stage holds an `lw`/`sw` access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID load enable.
- `ifid_flush` out 1: clear IF/ID to NOP.
- `idex_flush` out 1: clear ID/EX controls.
- `idex_bubble` out 1: insert a zero-control bubble into ID/EX.
- `pipe_hold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `mem_err` out 1: sticky memory-timeout error.
- `state` out 2: current FSM state.
- `stall_cnt` out `CNT_W`: load-use plus memory-wait stall cycles.
- `flush_cnt` out `CNT_W`: flush events.

## Operation
FSM state encodings: RUN=00, MEM_WAIT=01, ERROR=10. Outputs are a combinational decode of the current state and the inputs.

Hazard conditions:
- Load-use `lu` = `ex_mem_read` && `ex_rt`≠0 && (`ex_rt`==`id_rs` || (`id_uses_rt` && `ex_rt`==`id_rt`)).
- Memory wait `mw` = `mem_req` && !`mem_ready`.

RUN, evaluated in strict priority order:
1. `mw`: `pc_write`=`ifid_write`=0, `pipe_hold`=1, no flush or bubble. Wait counter loads 1; next state MEM_WAIT.
2. `ex_branch_taken`: `ifid_flush`=`idex_flush`=1, `pc_write`=1. This overrides `lu` and `id_jump`.
3. `id_jump`: `ifid_flush`=1, `pc_write`=1, `ifid_write`=1.
4. `lu`: `pc_write`=`ifid_write`=0, `idex_bubble`=1.
5. Otherwise: `pc_write`=`ifid_write`=1, all other controls 0.

MEM_WAIT:
- While `mem_ready`=0: hold exactly as in RUN item 1, and the wait counter increments.
- When the wait counter reaches `MEM_TIMEOUT` with `mem_ready` still 0: next state ERROR.
- When `mem_ready`=1: release `pipe_hold` in the same cycle, apply RUN items 2–5 in that cycle, next state RUN.
- A `mem_ready` arriving in the same cycle the counter reaches `MEM_TIMEOUT` wins: next state RUN, no error.

ERROR:
- `pc_write`=`ifid_write`=0, `pipe_hold`=1, `mem_err`=1.
- All other inputs are ignored. The block leaves ERROR only on `rst`.

Register 0 never causes a load-use stall.

## Timing
- Hazard response is zero-latency: outputs react combinationally in the cycle the condition is present.
- State and counters update on the rising edge.
- Load-use stall lasts exactly 1 cycle. The next cycle sees a bubble in ID/EX, so `ex_mem_read`=0.
- An access with `mem_ready` asserted k cycles after `mem_req` produces exactly k hold cycles, for k ≤ `MEM_TIMEOUT`.
- The wait counter is ⌈log2(`MEM_TIMEOUT`+1)⌉ bits wide and resets to 0 on every entry to RUN.
- While `rst`=1 (outputs forced to these values, registers cleared):
  - state=RUN, `pc_write`=`ifid_write`=0, `pipe_hold`=0, flushes=0, `idex_bubble`=1, `mem_err`=0, counters=0.
  - Reset asserted mid-wait or in ERROR returns to RUN on the next edge.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `lu` stall or memory hold. ERROR cycles do not count.
  - `flush_cnt` increments on each cycle with `ifid_flush`=1.
  - Both counters saturate at 2^`CNT_W`−1.
- `HAZ_PERF_CNT_EN` undefined: both counter ports are tied to 0 and no counter flops are synthesized.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8 → one cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; `stall_cnt`=1. Repeating with `ex_rt`=0 → no stall.
- Branch over load-use: `ex_branch_taken`=1 together with the `lu` condition → `ifid_flush`=`idex_flush`=1, `pc_write`=1, `idex_bubble`=0; `flush_cnt`=1.
- Memory wait: `mem_req`=1, `mem_ready` rises on cycle 3 → `pipe_hold`=1 for cycles 0–2, state=01, release on cycle 3, `stall_cnt`=3.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` held at 0 → state=10, `mem_err`=1 sticky; a later `mem_ready`=1 has no effect.
- Timeout edge: `mem_ready`=1 exactly on the cycle the counter reaches 4 → back to RUN, `mem_err`=0.
- Reset mid-wait: `rst`=1 during MEM_WAIT → next edge state=00, counters=0, `mem_err`=0.
